// File: rtl/au_pkg.sv
// Shared types and constants for the 32-bit arithmetic unit and its sequencer.
package au_pkg;

    localparam int AU_W = 32;

    typedef enum logic [1:0] {
        AU_ADD = 2'b00,
        AU_SUB = 2'b01,
        AU_MUL = 2'b10,
        AU_DIV = 2'b11
    } au_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } au_seq_state_e;

    typedef struct packed {
        logic [AU_W-1:0] s;
        logic [AU_W-1:0] hi;
        logic [AU_W-1:0] lo;
        logic            zero;
        logic            dbz;
    } au_rsp_t;

endpackage

// File: rtl/au_sequencer_if.sv
// Request/response handshake bundle between a requester and the AU sequencer.
interface au_sequencer_if;
    import au_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [AU_W-1:0] req_a;
    logic [AU_W-1:0] req_b;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [AU_W-1:0] rsp_s;
    logic [AU_W-1:0] rsp_hi;
    logic [AU_W-1:0] rsp_lo;
    logic            rsp_zero;
    logic            rsp_dbz;

    // Requester side: issues operations and consumes responses.
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_hi, rsp_lo, rsp_zero, rsp_dbz
    );

    // Sequencer side: accepts operations and presents responses.
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_hi, rsp_lo, rsp_zero, rsp_dbz
    );

endinterface

// File: rtl/au_sequencer.sv
// Issue/complete controller for AU_32b: launches one operation at a time,
// waits out its fixed latency, and holds the captured result for the consumer.
module au_sequencer
    import au_pkg::*;
#(
    parameter int ADDSUB_CYCLES = 1,
    parameter int MUL_CYCLES    = 32,
    parameter int DIV_CYCLES    = 32,
    parameter int CNT_W         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    au_sequencer_if.slave    bus,
    output logic             busy,
    output logic [AU_W-1:0]  au_a,
    output logic [AU_W-1:0]  au_b,
    output logic [1:0]       au_op,
    output logic             au_rst_n,
    input  logic [AU_W-1:0]  au_s,
    input  logic [AU_W-1:0]  au_hi,
    input  logic [AU_W-1:0]  au_lo,
    input  logic             au_zero
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_LAUNCH = 2'(LAUNCH);
    localparam logic [1:0] S_RUN    = 2'(RUN);
    localparam logic [1:0] S_DONE   = 2'(DONE);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_cnt;
    logic             launch_n;
    au_rsp_t          rsp;
    logic             is_dbz;

    // Latency to wait out for the operation being offered.
    always_comb begin
        load_cnt = CNT_W'(ADDSUB_CYCLES);
        case (bus.req_op)
            AU_MUL:  load_cnt = CNT_W'(MUL_CYCLES);
            AU_DIV:  load_cnt = CNT_W'(DIV_CYCLES);
            default: load_cnt = CNT_W'(ADDSUB_CYCLES);
        endcase
    end

    assign is_dbz = (bus.req_op == AU_DIV) && (bus.req_b == '0);

    // Main FSM: accept, pulse the AU reset, count latency, capture and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            launch_n <= 1'b1;
            au_a     <= '0;
            au_b     <= '0;
            au_op    <= 2'b00;
            rsp      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        au_a  <= bus.req_a;
                        au_b  <= bus.req_b;
                        au_op <= bus.req_op;
                        cnt   <= load_cnt;
                        if (is_dbz) begin
                            rsp     <= '0;
                            rsp.dbz <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            launch_n <= 1'b0;
                            state    <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    launch_n <= 1'b1;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (cnt <= CNT_W'(1)) begin
                        rsp.s    <= au_s;
                        rsp.hi   <= au_hi;
                        rsp.lo   <= au_lo;
                        rsp.zero <= au_zero;
                        rsp.dbz  <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign au_rst_n      = rst_n & launch_n;
    assign busy          = (state != S_IDLE);
    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_DONE);
    assign bus.rsp_s     = rsp.s;
    assign bus.rsp_hi    = rsp.hi;
    assign bus.rsp_lo    = rsp.lo;
    assign bus.rsp_zero  = rsp.zero;
    assign bus.rsp_dbz   = rsp.dbz;

endmodule

// File: tb/tb_au_sequencer.sv
// Directed testbench for au_sequencer with a cycle-accurate behavioural AU.
module tb_au_sequencer;
    import au_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [31:0] au_a;
    logic [31:0] au_b;
    logic [1:0]  au_op;
    logic        au_rst_n;
    logic [31:0] au_s;
    logic [31:0] au_hi;
    logic [31:0] au_lo;
    logic        au_zero;

    int check_count;
    int pass_count;

    au_sequencer_if bus();

    au_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .au_a     (au_a),
        .au_b     (au_b),
        .au_op    (au_op),
        .au_rst_n (au_rst_n),
        .au_s     (au_s),
        .au_hi    (au_hi),
        .au_lo    (au_lo),
        .au_zero  (au_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AU model: cycles elapsed since the last AU reset.
    logic [5:0] au_cnt;
    always_ff @(posedge clk or negedge au_rst_n) begin
        if (!au_rst_n) au_cnt <= '0;
        else if (au_cnt != 6'd63) au_cnt <= au_cnt + 6'd1;
    end

    // AU model outputs: garbage until the op's latency has elapsed.
    logic [63:0] prod;
    always_comb begin
        au_s    = 32'hBAD0_BAD0;
        au_hi   = 32'hBAD1_BAD1;
        au_lo   = 32'hBAD2_BAD2;
        au_zero = 1'b0;
        prod    = 64'(au_a) * 64'(au_b);
        if (au_op[1] == 1'b0 && au_cnt >= 6'd0) begin
            au_s    = (au_op == 2'b00) ? au_a + au_b : au_a - au_b;
            au_hi   = 32'h1111_1111;
            au_lo   = 32'h2222_2222;
            au_zero = (au_s == 32'd0);
        end else if (au_op[1] == 1'b1 && au_cnt >= 6'd31) begin
            au_s = 32'h3333_3333;
            if (au_op == 2'b10) begin
                au_hi = prod[63:32];
                au_lo = prod[31:0];
            end else if (au_b != 32'd0) begin
                au_hi = au_a % au_b;
                au_lo = au_a / au_b;
            end
            au_zero = (au_hi == 32'd0) && (au_lo == 32'd0);
        end
    end

    // Single comparison point for every check.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    // Offer one request while the sequencer is idle; returns just after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Track cycles from T+1 until rsp_valid; watch AU reset pulses and operand stability.
    task automatic waitResponse(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int latency,
                                output int pulses, output int pulse_at,
                                output bit stable_ok, output bit ready_low_ok);
        latency = 0; pulses = 0; pulse_at = 0; stable_ok = 1'b1; ready_low_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (au_rst_n === 1'b0) begin
                pulses++;
                if (pulse_at == 0) pulse_at = k;
            end
            if (au_a !== a || au_b !== b || au_op !== op) stable_ok = 1'b0;
            if (bus.req_ready !== 1'b0) ready_low_ok = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                latency = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    int lat, pulses, pulse_at;
    bit stable_ok, ready_low_ok, hold_ok, quiet_ok;

    // Directed test sequence.
    initial begin
        check_count = 0;
        pass_count  = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ctrl", {bus.req_ready, busy, bus.rsp_valid, au_rst_n}, 4'b1000);
        checkOutput("rst_rsp", {bus.rsp_s, bus.rsp_zero, bus.rsp_dbz}, 34'd0);
        checkOutput("rst_au_ops", {au_a, au_b, au_op}, 66'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_ready", {bus.req_ready, busy}, 2'b10);

        // Add 7+3.
        applyStimulus(2'b00, 32'd7, 32'd3);
        waitResponse(2'b00, 32'd7, 32'd3, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("add_latency", 64'(lat), 64'd3);
        checkOutput("add_pulses", 64'(pulses), 64'd1);
        checkOutput("add_pulse_at", 64'(pulse_at), 64'd1);
        checkOutput("add_s", 64'(bus.rsp_s), 64'd10);
        checkOutput("add_zero_dbz", {bus.rsp_zero, bus.rsp_dbz}, 2'b00);
        @(posedge clk);
        #1;

        // Sub 5-5.
        applyStimulus(2'b01, 32'd5, 32'd5);
        waitResponse(2'b01, 32'd5, 32'd5, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("sub_latency", 64'(lat), 64'd3);
        checkOutput("sub_s_zero", {bus.rsp_s, bus.rsp_zero}, {32'd0, 1'b1});
        @(posedge clk);
        #1;

        // Mul 7x3.
        applyStimulus(2'b10, 32'd7, 32'd3);
        waitResponse(2'b10, 32'd7, 32'd3, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("mul_latency", 64'(lat), 64'd34);
        checkOutput("mul_pulses", 64'(pulses), 64'd1);
        checkOutput("mul_hi_lo", {bus.rsp_hi, bus.rsp_lo}, {32'd0, 32'd21});
        checkOutput("mul_ops_stable", 64'(stable_ok), 64'd1);
        checkOutput("mul_ready_low", 64'(ready_low_ok), 64'd1);
        @(posedge clk);
        #1;

        // Div 7/3.
        applyStimulus(2'b11, 32'd7, 32'd3);
        waitResponse(2'b11, 32'd7, 32'd3, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("div_latency", 64'(lat), 64'd34);
        checkOutput("div_hi_lo", {bus.rsp_hi, bus.rsp_lo}, {32'd1, 32'd2});
        checkOutput("div_dbz", 64'(bus.rsp_dbz), 64'd0);
        @(posedge clk);
        #1;

        // Div 7/0 trapped without running the AU.
        applyStimulus(2'b11, 32'd7, 32'd0);
        waitResponse(2'b11, 32'd7, 32'd0, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("dbz_latency", 64'(lat), 64'd1);
        checkOutput("dbz_pulses", 64'(pulses), 64'd0);
        checkOutput("dbz_flag", {bus.rsp_dbz, bus.rsp_zero}, 2'b10);
        checkOutput("dbz_hi_lo", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        @(posedge clk);
        #1;

        // Backpressure on add 0xFFFFFFFF+1 while a new request waits.
        bus.rsp_ready = 1'b0;
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd1);
        waitResponse(2'b00, 32'hFFFF_FFFF, 32'd1, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("bp_latency", 64'(lat), 64'd3);
        checkOutput("bp_s_zero", {bus.rsp_s, bus.rsp_zero}, {32'd0, 1'b1});
        bus.req_op = 2'b00;
        bus.req_a = 32'd1;
        bus.req_b = 32'd1;
        bus.req_valid = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_s !== 32'd0 || bus.rsp_zero !== 1'b1 ||
                bus.req_ready !== 1'b0 || au_a !== 32'hFFFF_FFFF) hold_ok = 1'b0;
        end
        checkOutput("bp_hold", 64'(hold_ok), 64'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle_after_hs", {busy, bus.req_ready, bus.rsp_valid}, 3'b010);
        checkOutput("bp_rsp_kept", {bus.rsp_s, bus.rsp_zero}, {32'd0, 1'b1});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("bp_next_accept", {busy, au_a}, {1'b1, 32'd1});
        waitResponse(2'b00, 32'd1, 32'd1, lat, pulses, pulse_at, stable_ok, ready_low_ok);
        checkOutput("bp_next_s", {64'(lat), bus.rsp_s}, {64'd3, 32'd2});
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        applyStimulus(2'b10, 32'd7, 32'd3);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ctrl", {bus.req_ready, busy, bus.rsp_valid, au_rst_n}, 4'b1000);
        checkOutput("mid_rst_ops", {au_a, au_b, au_op}, 66'd0);
        checkOutput("mid_rst_rsp", {bus.rsp_s, bus.rsp_lo}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
        end
        checkOutput("mid_no_response", 64'(quiet_ok), 64'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/au_sequencer.md
Name: au_sequencer

Overview:
Issue/complete controller for the 32-bit arithmetic unit (AU_32b). It accepts one operation at a time from a requester over a valid/ready handshake. It drives and holds the AU operands and opcode, and restarts the AU for each operation. It counts the operation's fixed latency: 1 cycle for add/sub, 32 cycles for multiply/divide. It then captures s/hi/lo/zero into a response register and holds them until the consumer accepts. Divide-by-zero is trapped without running the AU.

Parameters:
ADDSUB_CYCLES, 1, AU cycles from launch until s/zero are valid for add/sub
MUL_CYCLES, 32, AU cycles from launch until hi/lo are valid for multiply
DIV_CYCLES, 32, AU cycles from launch until hi/lo are valid for divide
CNT_W, 6, cycle-counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_op  in  2  00 add, 01 sub, 10 mul, 11 div
req_a  in  32  operand a
req_b  in  32  operand b
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_s  out  32  add/sub result
rsp_hi  out  32  product high word / divide remainder
rsp_lo  out  32  product low word / divide quotient
rsp_zero  out  1  AU zero flag captured with the result
rsp_dbz  out  1  divide-by-zero trap
busy  out  1  high in any state other than IDLE
au_a  out  32  AU operand a
au_b  out  32  AU operand b
au_op  out  2  AU ALUop
au_rst_n  out  1  AU reset: rst_n AND launch_n; pulses low for one cycle per launch
au_s  in  32  AU s
au_hi  in  32  AU hi
au_lo  in  32  AU lo
au_zero  in  1  AU zero

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; busy=0; rsp_s/hi/lo=0; rsp_zero=0; rsp_dbz=0; au_a/au_b=0; au_op=00; launch_n=1.
- au_rst_n is low whenever rst_n is low.

State machine (IDLE, LAUNCH, RUN, DONE):
- IDLE: accept when req_valid && req_ready.
  - On accept, latch req_a/req_b/req_op into au_a/au_b/au_op.
  - Load the counter with the latency for the op.
  - If op=11 and req_b=0: go to DONE with rsp_dbz=1, rsp_s/hi/lo=0, rsp_zero=0. launch_n is not pulsed and the AU is not run.
  - Otherwise: set launch_n=0 and go to LAUNCH.
- LAUNCH: one cycle with au_rst_n low. Set launch_n=1 and go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - On the cycle the counter reads 1, capture au_s/au_hi/au_lo/au_zero into the rsp_* registers, clear rsp_dbz, and go to DONE.
- DONE:
  - rsp_valid=1; all rsp_* are held stable.
  - On rsp_ready, clear rsp_valid and go to IDLE. rsp_* keep their values until the next capture.

Latency and operand rules:
- Accept edge = T. rsp_valid is first high in cycle T+2+N, where N is the op's latency: add/sub T+3, mul/div T+34.
- Divide-by-zero: rsp_valid high in cycle T+1.
- au_a/au_b/au_op are constant from T+1 until the next accept. The AU sees stable inputs for the whole run.

Throughput:
- One operation in flight. req_ready=0 from T+1 until return to IDLE.
- No acceptance in the DONE→IDLE cycle: the first new accept is one cycle after rsp_ready handshake.
- Back-to-back maximum for add: 1 op per 4 cycles.

Other rules:
- Unused result fields (hi/lo for add/sub, s for mul/div) capture whatever the AU drives; the consumer ignores them.
- Reset mid-operation: everything returns to reset values immediately and the in-flight op is discarded. No response is ever produced for it.
- req_valid while busy is ignored and not queued. The requester must hold req_valid until accepted.
- rsp_ready while not rsp_valid has no effect.
- Counter never underflows; values 0 and 1 in RUN both force capture.

Decomposition:
- Shared package au_pkg:
  - enum au_op_e {AU_ADD=2'b00, AU_SUB=2'b01, AU_MUL=2'b10, AU_DIV=2'b11}
  - enum au_seq_state_e {IDLE, LAUNCH, RUN, DONE}
  - localparam AU_W=32
  - struct au_rsp_t {s, hi, lo, zero, dbz}
- No sub-module: single FSM with counter. AU_32b is instantiated by the parent, not inside this block.

Test Plan:
- Add 7+3, rsp_ready=1 → rsp_valid at T+3, rsp_s=10, rsp_zero=0; exactly one au_rst_n low pulse at T+1.
- Sub 5-5 → rsp_s=0, rsp_zero=1 at T+3.
- Mul 7×3 → rsp_hi=0, rsp_lo=21 at T+34; req_ready=0 and au_a/au_b/au_op constant for T+1..T+34.
- Div 7/3 → rsp_lo=2, rsp_hi=1, rsp_dbz=0 at T+34.
- Div 7/0 → rsp_dbz=1, rsp_hi=rsp_lo=0 at T+1; au_rst_n never low.
- Backpressure:
  - With rsp_ready=0 for 5 cycles after add 0xFFFFFFFF+1: rsp_s=0, rsp_zero=1 held stable, and a new req_valid is not accepted.
  - After rsp_ready, the next accept occurs one cycle later.
  - Separately, rst_n=0 at T+15 of a mul → immediate reset values, and no response after release.
